// File: rtl/fpu_pkg.sv
// Shared FPU definitions: 5-bit op codes, per-op latency counts and the
// issue sequencer state type.
package fpu_pkg;

    localparam logic [4:0] FADD   = 5'b10000;
    localparam logic [4:0] FSUB   = 5'b10001;
    localparam logic [4:0] FMUL   = 5'b10010;
    localparam logic [4:0] FDIV   = 5'b10011;
    localparam logic [4:0] FSQRT  = 5'b10100;
    localparam logic [4:0] FLE    = 5'b10101;
    localparam logic [4:0] FLT    = 5'b10110;
    localparam logic [4:0] FEQ    = 5'b10111;
    localparam logic [4:0] FSGNJ  = 5'b11000;
    localparam logic [4:0] FSGNJN = 5'b11001;
    localparam logic [4:0] FSGNJX = 5'b11010;
    localparam logic [4:0] FCVTSW = 5'b11100;
    localparam logic [4:0] FCVTWS = 5'b11101;

    // Extra cycles beyond the single registered stage each sub-unit has.
    localparam int LAT_FADD   = 5;
    localparam int LAT_FSUB   = 5;
    localparam int LAT_FMUL   = 5;
    localparam int LAT_FDIV   = 8;
    localparam int LAT_FSQRT  = 3;
    localparam int LAT_FLE    = 0;
    localparam int LAT_FLT    = 0;
    localparam int LAT_FEQ    = 0;
    localparam int LAT_FSGNJ  = 0;
    localparam int LAT_FSGNJN = 0;
    localparam int LAT_FSGNJX = 0;
    localparam int LAT_FCVTSW = 2;
    localparam int LAT_FCVTWS = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/fpu_issue_seq.sv
// Decoder-to-FPU issue sequencer: holds one float op on the FPU inputs for
// its latency, then emits a single write-back beat and flags RAW hazards.
module fpu_issue_seq
    import fpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CNT_W   = 4,
    parameter int PERF_EN = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       fpu_cont_i,
    input  logic [CNT_W-1:0] fpu_stall_i,
    input  logic [XLEN-1:0]  x1_i,
    input  logic [XLEN-1:0]  x2_i,
    input  logic [4:0]       rd_i,
    input  logic             rd_is_float_i,
    input  logic             flush,
    output logic [4:0]       fpu_cont_o,
    output logic [XLEN-1:0]  fpu_x1_o,
    output logic [XLEN-1:0]  fpu_x2_o,
    input  logic [XLEN-1:0]  fpu_y,
    output logic             busy,
    input  logic [4:0]       rs1_q,
    input  logic [4:0]       rs2_q,
    input  logic             rs_is_float_q,
    output logic             raw_hazard,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic             wb_is_float,
    output logic [XLEN-1:0]  wb_data,
    output logic             illegal_op,
    output logic [31:0]      perf_cnt
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       cont_q, cont_d;
    logic [XLEN-1:0]  x1_q, x1_d;
    logic [XLEN-1:0]  x2_q, x2_d;
    logic [4:0]       rd_q, rd_d;
    logic             rd_float_q, rd_float_d;
    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_float_q, wb_float_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic             illegal_q, illegal_d;
    logic [31:0]      perf_q, perf_d;

    logic accept;
    logic rd_match;
    logic dest_is_x0;

    assign issue_ready = (state_q == IDLE) && !flush;
    assign busy        = (state_q == RUN);
    assign accept      = issue_valid && issue_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cont_d     = cont_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        rd_d       = rd_q;
        rd_float_d = rd_float_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_float_d = wb_float_q;
        wb_data_d  = wb_data_q;
        illegal_d  = 1'b0;
        perf_d     = perf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Bit 4 of the op code marks a valid FPU operation.
                    if (fpu_cont_i[4]) begin
                        cont_d     = fpu_cont_i;
                        x1_d       = x1_i;
                        x2_d       = x2_i;
                        rd_d       = rd_i;
                        rd_float_d = rd_is_float_i;
                        cnt_d      = fpu_stall_i;
                        state_d    = RUN;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_float_d = rd_float_q;
                    wb_data_d  = fpu_y;
                    state_d    = IDLE;
                    if (PERF_EN != 0) begin
                        perf_d = perf_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cont_q     <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            rd_q       <= '0;
            rd_float_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_float_q <= 1'b0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
            perf_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cont_q     <= cont_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            rd_q       <= rd_d;
            rd_float_q <= rd_float_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_float_q <= wb_float_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
            perf_q     <= perf_d;
        end
    end

    // Integer x0 is hardwired to zero, so a pending write to it is never a hazard.
    assign rd_match   = (rs1_q == rd_q) || (rs2_q == rd_q);
    assign dest_is_x0 = !rd_float_q && (rd_q == 5'd0);
    assign raw_hazard = busy && (rs_is_float_q == rd_float_q) && rd_match && !dest_is_x0;

    assign fpu_cont_o  = cont_q;
    assign fpu_x1_o    = x1_q;
    assign fpu_x2_o    = x2_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_is_float = wb_float_q;
    assign wb_data     = wb_data_q;
    assign illegal_op  = illegal_q;
    assign perf_cnt    = perf_q;

endmodule
